// File: rtl/uart_arith_pkg.sv
// Shared types and constants for the UART baud-rate arithmetic blocks
// (shift_mult feeds shift_div).
package uart_arith_pkg;

    localparam int DVD_W_DEF = 24;
    localparam int DVS_W_DEF = 16;
    localparam int CNT_WIDTH = $clog2(DVD_W_DEF + 1);

    typedef logic [DVD_W_DEF-1:0] dividend_word_t;
    typedef logic [DVS_W_DEF-1:0] divisor_word_t;
    typedef logic [DVD_W_DEF-1:0] quotient_word_t;
    typedef logic [DVS_W_DEF-1:0] remainder_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_e;

endpackage

// File: rtl/shift_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// remainder, trial-subtract the divisor and keep the result if it fits.
module shift_div_step #(
    parameter int DIVISOR_WIDTH = 16
) (
    input  logic [DIVISOR_WIDTH-1:0] rem_in,
    input  logic                     bit_in,
    input  logic [DIVISOR_WIDTH-1:0] divisor,
    output logic [DIVISOR_WIDTH-1:0] rem_out,
    output logic                     q_bit
);

    // Partial remainder is one bit wider than the divisor so the shifted
    // value never loses its carry before the compare.
    logic [DIVISOR_WIDTH:0] prem;

    // Trial subtract; the result always fits back in DIVISOR_WIDTH bits
    // because the kept remainder stays below the divisor.
    always_comb begin
        prem    = {rem_in, bit_in};
        q_bit   = (prem >= {1'b0, divisor});
        rem_out = DIVISOR_WIDTH'(q_bit ? (prem - {1'b0, divisor}) : prem);
    end

endmodule

// File: rtl/shift_div.sv
// Sequential restoring divider, one quotient bit per clock.
// Dividend bits shift out of the top of the working register while
// quotient bits shift in at the bottom, so one register serves both.
module shift_div
    import uart_arith_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DVD_W_DEF,
    parameter int DIVISOR_WIDTH  = DVS_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    input  logic                      start,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder,
    output logic                      busy,
    output logic                      done,
    output logic                      div_by_zero
);

    localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

    div_state_e                state, state_nxt;
    logic [CW-1:0]             cnt;
    logic [DIVIDEND_WIDTH-1:0] work;
    logic [DIVISOR_WIDTH-1:0]  dvs_q;
    logic [DIVISOR_WIDTH-1:0]  prem;
    logic [DIVISOR_WIDTH-1:0]  step_rem;
    logic                      step_q;
    logic [DIVIDEND_WIDTH-1:0] work_nxt;
    logic                      accept, dz, last;

    assign accept   = (state == IDLE) && start && (divisor != '0);
    assign dz       = (state == IDLE) && start && (divisor == '0);
    assign last     = (state == RUN)  && (cnt == CW'(1));
    assign work_nxt = {work[DIVIDEND_WIDTH-2:0], step_q};

    shift_div_step #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_step (
        .rem_in  (prem),
        .bit_in  (work[DIVIDEND_WIDTH-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: divide-by-zero resolves in IDLE without entering RUN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state == RUN);
    end

    // Datapath: operand latch, per-bit step, result registers and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            work        <= '0;
            dvs_q       <= '0;
            prem        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                work        <= dividend;
                dvs_q       <= divisor;
                prem        <= '0;
                cnt         <= CW'(DIVIDEND_WIDTH);
                div_by_zero <= 1'b0;
            end else if (dz) begin
                quotient    <= '1;
                remainder   <= '0;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
            end else if (state == RUN) begin
                work <= work_nxt;
                prem <= step_rem;
                cnt  <= cnt - CW'(1);
                if (last) begin
                    quotient  <= work_nxt;
                    remainder <= step_rem;
                    done      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_div.sv
// Directed and randomized checks of shift_div against plain / and %.
module tb_shift_div;
    import uart_arith_pkg::*;

    localparam int DW = DVD_W_DEF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    dividend_word_t  dividend = '0;
    divisor_word_t   divisor = '0;
    quotient_word_t  quotient;
    remainder_word_t remainder;
    logic            busy, done, div_by_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_div dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dividend    (dividend),
        .divisor     (divisor),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands with start for exactly one edge; returns at the
    // negedge following the accept edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        dividend = dividend_word_t'(a);
        divisor  = divisor_word_t'(b);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Count busy cycles until results are ready, bounded by a watchdog.
    task automatic wait_done(output int bcyc);
        bcyc = 0;
        while (busy === 1'b1 && bcyc <= DW + 1) begin
            bcyc++;
            @(negedge clk);
        end
        chk("watchdog", 32'(bcyc <= DW), 32'd1);
        chk("done_pulse", 32'(done), 32'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int bcyc);
        launch(a, b);
        wait_done(bcyc);
    endtask

    initial begin
        int bc;
        logic [31:0] a, b, m;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_q",   32'(quotient), 32'd0);
        chk("rst_r",   32'(remainder), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic divide, latency and single done pulse
        do_op(1000000, 4800, bc);
        chk("basic_q", 32'(quotient), 32'd208);
        chk("basic_r", 32'(remainder), 32'd1600);
        chk("basic_busy_cycles", 32'(bc), 32'(DW));
        @(negedge clk);
        chk("basic_done_once", 32'(done), 32'd0);

        // Divide by zero resolves on the start edge, no busy
        launch(12345, 0);
        chk("dz_done", 32'(done), 32'd1);
        chk("dz_busy", 32'(busy), 32'd0);
        chk("dz_q", 32'(quotient), 32'hFFFFFF);
        chk("dz_r", 32'(remainder), 32'd0);
        chk("dz_flag", 32'(div_by_zero), 32'd1);
        do_op(10, 3, bc);
        chk("after_dz_q", 32'(quotient), 32'd3);
        chk("after_dz_r", 32'(remainder), 32'd1);
        chk("after_dz_flag", 32'(div_by_zero), 32'd0);

        // Edge operands
        do_op(32'hFFFFFF, 1, bc);
        chk("max_by1_q", 32'(quotient), 32'hFFFFFF);
        chk("max_by1_r", 32'(remainder), 32'd0);
        do_op(0, 7, bc);
        chk("zero_q", 32'(quotient), 32'd0);
        chk("zero_r", 32'(remainder), 32'd0);
        do_op(5, 32'hFFFF, bc);
        chk("small_q", 32'(quotient), 32'd0);
        chk("small_r", 32'(remainder), 32'd5);

        // Start while busy is ignored; operands change mid-op
        launch(100, 7);
        repeat (4) @(negedge clk);
        dividend = 24'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 24'h123456;
        divisor  = 16'h0001;
        chk("hold_r", 32'(remainder), 32'd5);
        chk("hold_busy", 32'(busy), 32'd1);
        wait_done(bc);
        chk("ignore_q", 32'(quotient), 32'd14);
        chk("ignore_r", 32'(remainder), 32'd2);

        // Reset mid-operation clears outputs without a clock edge
        launch(1000000, 4800);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_q", 32'(quotient), 32'd0);
        chk("midrst_r", 32'(remainder), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(81, 9, bc);
        chk("post_rst_q", 32'(quotient), 32'd9);
        chk("post_rst_r", 32'(remainder), 32'd0);

        // Random operands against plain arithmetic
        for (int i = 0; i < 2000; i++) begin
            a = $urandom() & 32'hFFFFFF;
            b = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : 32'($urandom_range(1, 65535));
            do_op(a, b, bc);
            chk("rand_q", 32'(quotient), a / b);
            chk("rand_r", 32'(remainder), a % b);
        end

        // Multiplier product chained in as the dividend
        for (int i = 0; i < 600; i++) begin
            m = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(1, 65535));
            do_op(m * b, b, bc);
            chk("chain_q", 32'(quotient), m);
            chk("chain_r", 32'(remainder), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
